// File: rtl/sentinel_auth_sequencer_if.sv
// Sentinel authorization sequencer bundle.
// master drives key/enable inputs; slave is the sequencer.
interface sentinel_auth_sequencer_if #(
  parameter int MAX_FAILS = 3
);
  localparam int FW = $clog2(MAX_FAILS + 1);

  logic          ena;
  logic          glitch;
  logic [7:0]    key_in;
  logic          key_match;
  logic [7:0]    seg_out;
  logic          glow_en;
  logic          attempt_pulse;
  logic          lockout;
  logic [FW-1:0] fail_count;

  modport master (
    output ena,
    output glitch,
    output key_in,
    output key_match,
    input  seg_out,
    input  glow_en,
    input  attempt_pulse,
    input  lockout,
    input  fail_count
  );

  modport slave (
    input  ena,
    input  glitch,
    input  key_in,
    input  key_match,
    output seg_out,
    output glow_en,
    output attempt_pulse,
    output lockout,
    output fail_count
  );
endinterface

// File: rtl/sentinel_auth_sequencer.sv
// Sentinel key-entry sequencer: debounce, one attempt per
// stable key, fail tracking, timed lockout, session expiry.
module sentinel_auth_sequencer #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int MAX_FAILS    = 3,
  parameter int LOCKOUT_CYC  = 1024,
  parameter int SESSION_CYC  = 4096
) (
  input logic clk,
  input logic rst,
  sentinel_auth_sequencer_if.slave bus
);

  localparam int SW   = $clog2(DEBOUNCE_CYC);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int TMAX = (LOCKOUT_CYC > SESSION_CYC) ?
                        LOCKOUT_CYC : SESSION_CYC;
  localparam int TW   = $clog2(TMAX);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCKOUT_CYC - 1);
  localparam logic [TW-1:0] SESS_LAST   = TW'(SESSION_CYC - 1);
  localparam logic [FW-1:0] FAIL_PRE    = FW'(MAX_FAILS - 1);
  localparam logic [FW-1:0] FAIL_SAT    = FW'(MAX_FAILS);

  localparam logic [7:0] SEG_LOCK  = 8'hC7;
  localparam logic [7:0] SEG_OPEN  = 8'hC1;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [2:0] {
    S_LOCKED,
    S_SETTLE,
    S_CHECK,
    S_UNLOCKED,
    S_LOCKOUT
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    last_key_q, last_key_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;

  logic key_chg;
  assign key_chg = (bus.key_in != last_key_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LOCKED;
      last_key_q <= 8'h00;
      settle_q   <= '0;
      fail_q     <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_key_q <= last_key_d;
      settle_q   <= settle_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_key_d = last_key_q;
    settle_d   = settle_q;
    fail_d     = fail_q;
    timer_d    = timer_q;
    // glitch outranks the power-state hold
    if (bus.glitch) begin
      state_d    = S_LOCKOUT;
      timer_d    = '0;
      last_key_d = bus.key_in;
    end else if (bus.ena) begin
      unique case (state_q)
        S_LOCKED: begin
          if (key_chg) begin
            state_d    = S_SETTLE;
            last_key_d = bus.key_in;
            settle_d   = '0;
          end
        end
        S_SETTLE: begin
          if (key_chg) begin
            last_key_d = bus.key_in;
            settle_d   = '0;
          end else if (settle_q == SETTLE_LAST) begin
            state_d = S_CHECK;
          end else begin
            settle_d = settle_q + SW'(1);
          end
        end
        S_CHECK: begin
          timer_d = '0;
          if (bus.key_match) begin
            state_d = S_UNLOCKED;
            fail_d  = '0;
          end else if (fail_q == FAIL_PRE) begin
            state_d = S_LOCKOUT;
            fail_d  = FAIL_SAT;
          end else begin
            state_d = S_LOCKED;
            fail_d  = fail_q + FW'(1);
          end
        end
        S_UNLOCKED: begin
          if (key_chg) begin
            state_d    = S_SETTLE;
            last_key_d = bus.key_in;
            settle_d   = '0;
          end else if (timer_q == SESS_LAST) begin
            state_d = S_LOCKED;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_LOCKOUT: begin
          // track the key so one held through lockout is not evaluated
          last_key_d = bus.key_in;
          if (timer_q == LOCK_LAST) begin
            state_d = S_LOCKED;
            fail_d  = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: state_d = S_LOCKED;
      endcase
    end
  end

  logic [7:0] seg;

  always_comb begin
    seg = SEG_LOCK;
    unique case (state_q)
      S_UNLOCKED: seg = SEG_OPEN;
      S_LOCKOUT:  seg = SEG_DASH;
      default:    seg = SEG_LOCK;
    endcase
  end

  assign bus.seg_out       = bus.ena ? seg : SEG_BLANK;
  assign bus.glow_en       = bus.ena && (state_q == S_UNLOCKED);
  assign bus.attempt_pulse = bus.ena && (state_q == S_CHECK);
  assign bus.lockout       = (state_q == S_LOCKOUT);
  assign bus.fail_count    = fail_q;

endmodule

// File: tb/tb_sentinel_auth_sequencer.sv
// Scoreboard bench for sentinel_auth_sequencer: directed phases
// then random key traffic against a countdown-style model.
module tb_sentinel_auth_sequencer;

  localparam int DEB = 16;
  localparam int MF  = 3;
  localparam int LOC = 1024;
  localparam int SES = 4096;
  localparam int FW  = $clog2(MF + 1);
  localparam logic [7:0] SECRET = 8'hB6;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_EVAL  = 2;
  localparam int M_OPEN  = 3;
  localparam int M_BLOCK = 4;

  typedef logic [10+FW:0] obs_t;
  typedef struct {
    int id;
    int val;
  } aux_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sentinel_auth_sequencer_if #(.MAX_FAILS(MF)) bus ();

  sentinel_auth_sequencer #(
    .DEBOUNCE_CYC(DEB),
    .MAX_FAILS(MF),
    .LOCKOUT_CYC(LOC),
    .SESSION_CYC(SES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  obs_t exp_q[$];
  aux_t aux_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int pulse_seen = 0;
  int run = 0;
  int last_run = 0;

  // reference: mode, key last seen, samples held, cycles left
  int mode;
  int held;
  int left;
  int fails;
  logic [7:0] seen_key;

  function automatic void model_reset();
    mode = M_IDLE;
    held = 0;
    left = 0;
    fails = 0;
    seen_key = 8'h00;
  endfunction

  function automatic obs_t expect_obs(input logic e);
    logic [7:0] s;
    if (!e) s = 8'hFF;
    else if (mode == M_OPEN) s = 8'hC1;
    else if (mode == M_BLOCK) s = 8'hBF;
    else s = 8'hC7;
    return {s, e && (mode == M_OPEN), e && (mode == M_EVAL),
            mode == M_BLOCK, FW'(fails)};
  endfunction

  function automatic void model_step(input logic e, input logic g,
                                     input logic [7:0] k,
                                     input logic m);
    if (g) begin
      mode = M_BLOCK;
      left = LOC;
      seen_key = k;
    end else if (e) begin
      if (mode == M_IDLE) begin
        if (k != seen_key) begin
          mode = M_WAIT;
          seen_key = k;
          held = 1;
        end
      end else if (mode == M_WAIT) begin
        if (k != seen_key) begin
          seen_key = k;
          held = 1;
        end else if (held == DEB) begin
          mode = M_EVAL;
        end else begin
          held++;
        end
      end else if (mode == M_EVAL) begin
        if (m) begin
          mode = M_OPEN;
          fails = 0;
          left = SES;
        end else if (fails + 1 >= MF) begin
          mode = M_BLOCK;
          fails = MF;
          left = LOC;
        end else begin
          fails++;
          mode = M_IDLE;
        end
      end else if (mode == M_OPEN) begin
        if (k != seen_key) begin
          mode = M_WAIT;
          seen_key = k;
          held = 1;
        end else if (left == 1) begin
          mode = M_IDLE;
        end else begin
          left--;
        end
      end else begin
        seen_key = k;
        if (left == 1) begin
          mode = M_IDLE;
          fails = 0;
        end else begin
          left--;
        end
      end
    end
  endfunction

  task automatic cyc(input logic r, input logic e, input logic g,
                     input logic [7:0] k, input logic m);
    @(posedge clk);
    #1;
    rst = r;
    bus.ena = e;
    bus.glitch = g;
    bus.key_in = k;
    bus.key_match = m;
    if (r) model_reset();
    exp_q.push_back(expect_obs(e));
    if (!r) model_step(e, g, k, m);
  endtask

  task automatic hold(input int n, input logic e, input logic g,
                      input logic [7:0] k);
    for (int i = 0; i < n; i++) cyc(1'b0, e, g, k, k == SECRET);
  endtask

  task automatic want(input int id, input int val);
    aux_t a;
    a.id = id;
    a.val = val;
    aux_q.push_back(a);
  endtask

  always @(negedge clk) begin : monitor
    obs_t act;
    obs_t ex;
    aux_t a;
    int got;
    act = {bus.seg_out, bus.glow_en, bus.attempt_pulse,
           bus.lockout, bus.fail_count};
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      n_cmp++;
      if (act !== ex) begin
        n_bad++;
        $display("FAIL outputs t=%0t got seg=%h glow=%b pulse=%b lock=%b fails=%0d want seg=%h glow=%b pulse=%b lock=%b fails=%0d",
                 $time, act[10+FW:3+FW], act[2+FW], act[1+FW],
                 act[FW], act[FW-1:0], ex[10+FW:3+FW], ex[2+FW],
                 ex[1+FW], ex[FW], ex[FW-1:0]);
      end
    end
    if (bus.attempt_pulse === 1'b1) pulse_seen++;
    if (bus.lockout === 1'b1) begin
      run++;
    end else begin
      if (run > 0) last_run = run;
      run = 0;
    end
    if (aux_q.size() > 0) begin
      a = aux_q.pop_front();
      got = (a.id == 0) ? pulse_seen : last_run;
      n_cmp++;
      if (got != a.val) begin
        n_bad++;
        $display("FAIL %s got %0d want %0d",
                 (a.id == 0) ? "pulse_total" : "lockout_len",
                 got, a.val);
      end
    end
  end

  logic [7:0] keys [4];
  logic [7:0] rk;
  logic rr, re, rg, rm;

  initial begin
    keys[0] = 8'hB6;
    keys[1] = 8'h11;
    keys[2] = 8'h22;
    keys[3] = 8'hB7;
    bus.ena = 1'b1;
    bus.glitch = 1'b0;
    bus.key_in = 8'h00;
    bus.key_match = 1'b0;
    model_reset();

    // reset state, enabled and disabled
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // good key unlocks
    hold(25, 1'b1, 1'b0, SECRET);
    want(0, 1);

    // bouncing key never evaluated
    for (int i = 0; i < 25; i++)
      hold(8, 1'b1, 1'b0, (i % 2 == 0) ? 8'hB7 : 8'hB6);
    want(0, 1);

    // three wrong keys then lockout, good key held inside it
    hold(20, 1'b1, 1'b0, 8'h11);
    hold(20, 1'b1, 1'b0, 8'h22);
    hold(20, 1'b1, 1'b0, 8'h33);
    hold(300, 1'b1, 1'b0, 8'h33);
    hold(900, 1'b1, 1'b0, SECRET);
    want(0, 4);
    want(1, LOC);

    // session expiry with key held
    hold(20, 1'b1, 1'b0, 8'h00);
    hold(20, 1'b1, 1'b0, SECRET);
    hold(4200, 1'b1, 1'b0, SECRET);
    want(0, 6);

    // glitch while unlocked, ena drop freezes lockout timer
    hold(20, 1'b1, 1'b0, 8'h00);
    hold(20, 1'b1, 1'b0, SECRET);
    hold(1, 1'b1, 1'b1, SECRET);
    hold(100, 1'b0, 1'b0, SECRET);
    hold(1100, 1'b1, 1'b0, SECRET);
    want(0, 8);
    want(1, LOC + 100);

    // reset in the middle of debounce
    hold(5, 1'b1, 1'b0, 8'h55);
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    hold(30, 1'b1, 1'b0, 8'h00);
    want(0, 8);

    // random traffic
    rk = SECRET;
    for (int i = 0; i < 20000; i++) begin
      rr = ($urandom_range(0, 2999) == 0);
      re = ($urandom_range(0, 9) != 0);
      rg = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 23) == 0) rk = keys[$urandom_range(0, 3)];
      if ($urandom_range(0, 5) == 0) rm = 1'($urandom_range(0, 1));
      else rm = (rk == SECRET);
      cyc(rr, re, rg, rk, rm);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
